// File: rtl/coin_payout.sv
// coin_payout: payout stage behind the vending FSM.
// It takes one product/change/refund result from the vending FSM and runs it to completion.
// A product first gets a fixed-length vend motor pulse.
// The owed amount is then paid from a value-2 hopper and a value-1 hopper.
// Each coin is one req/ack handshake on the shared hop_ack line.
// A hopper that runs dry or stops answering latches a sticky fault.
// The fault holds until reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   pdt          product release strobe (sampled only when idle)
//   cng          change owed, valid with pdt
//   rtn          cancel refund; a nonzero value starts a payout when idle
//   coin2_stock  value-2 hopper non-empty
//   coin1_stock  value-1 hopper non-empty
//   hop_ack      coin ejected acknowledge, shared by both hoppers
//   vend_motor   product motor drive
//   hop2_req     eject one value-2 coin
//   hop1_req     eject one value-1 coin
//   busy         high whenever a transaction is in progress or faulted
//   done         one-cycle pulse at transaction completion
//   paid_total   value paid in the current/last transaction
//   fault        sticky hopper fault
module coin_payout #(
  parameter int VEND_PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT       = 16,
  parameter int AMT_W             = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdt,
  input  logic [AMT_W-1:0] cng,
  input  logic [AMT_W-1:0] rtn,
  input  logic             coin2_stock,
  input  logic             coin1_stock,
  input  logic             hop_ack,
  output logic             vend_motor,
  output logic             hop2_req,
  output logic             hop1_req,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] paid_total,
  output logic             fault
);

  // One timer serves both the vend pulse and the handshake timeouts.
  localparam int TMAX = (ACK_TIMEOUT > VEND_PULSE_CYCLES) ? ACK_TIMEOUT : VEND_PULSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    VEND_LAST = TW'(VEND_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]    TIMER_ONE = TW'(1);
  localparam logic [TW-1:0]    TIMER_ZERO = {TW{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ZERO  = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);
  localparam logic [AMT_W-1:0] AMT_TWO   = AMT_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VEND   = 3'd1,
    ST_SELECT = 3'd2,
    ST_REQ2   = 3'd3,
    ST_REQ1   = 3'd4,
    ST_ACKLOW = 3'd5,
    ST_DONE   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [AMT_W-1:0] remain_r, remain_s;
  logic [AMT_W-1:0] paid_s;
  logic [TW-1:0]    timer_r, timer_s;

  // Next-state, remaining amount, paid total and timer decisions.
  always_comb begin
    state_s  = state_r;
    remain_s = remain_r;
    paid_s   = paid_total;
    timer_s  = timer_r;
    case (state_r)
      ST_IDLE: begin
        // pdt takes priority; a simultaneous refund request is dropped.
        if (pdt) begin
          remain_s = cng;
          paid_s   = AMT_ZERO;
          timer_s  = TIMER_ZERO;
          state_s  = ST_VEND;
        end else if (rtn != AMT_ZERO) begin
          remain_s = rtn;
          paid_s   = AMT_ZERO;
          timer_s  = TIMER_ZERO;
          state_s  = ST_SELECT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (timer_r == VEND_LAST) begin
          timer_s = TIMER_ZERO;
          state_s = ST_SELECT;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
      ST_SELECT: begin
        // Prefer the larger coin; fall back to value-1 coins when value-2 is empty.
        timer_s = TIMER_ZERO;
        if ((remain_r >= AMT_TWO) && coin2_stock) begin
          state_s = ST_REQ2;
        end else if ((remain_r >= AMT_ONE) && coin1_stock) begin
          state_s = ST_REQ1;
        end else if (remain_r == AMT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FAULT;
        end
      end
      ST_REQ2: begin
        // SELECT only enters here with remain >= 2, so the subtract cannot wrap.
        if (hop_ack) begin
          remain_s = remain_r - AMT_TWO;
          paid_s   = paid_total + AMT_TWO;
          timer_s  = TIMER_ZERO;
          state_s  = ST_ACKLOW;
        end else if (timer_r == ACK_LAST) begin
          state_s  = ST_FAULT;
        end else begin
          timer_s  = timer_r + TIMER_ONE;
        end
      end
      ST_REQ1: begin
        if (hop_ack) begin
          remain_s = remain_r - AMT_ONE;
          paid_s   = paid_total + AMT_ONE;
          timer_s  = TIMER_ZERO;
          state_s  = ST_ACKLOW;
        end else if (timer_r == ACK_LAST) begin
          state_s  = ST_FAULT;
        end else begin
          timer_s  = timer_r + TIMER_ONE;
        end
      end
      ST_ACKLOW: begin
        // The hopper must release ack before the next coin is requested.
        if (!hop_ack) begin
          timer_s = TIMER_ZERO;
          state_s = ST_SELECT;
        end else if (timer_r == ACK_LAST) begin
          state_s = ST_FAULT;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_FAULT: begin
        // remain and paid_total are frozen here for diagnosis.
        state_s = ST_FAULT;
      end
      default: begin
        state_s = ST_FAULT;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      remain_r   <= AMT_ZERO;
      timer_r    <= TIMER_ZERO;
      paid_total <= AMT_ZERO;
      vend_motor <= 1'b0;
      hop2_req   <= 1'b0;
      hop1_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_r    <= state_s;
      remain_r   <= remain_s;
      timer_r    <= timer_s;
      paid_total <= paid_s;
      vend_motor <= (state_s == ST_VEND);
      hop2_req   <= (state_s == ST_REQ2);
      hop1_req   <= (state_s == ST_REQ1);
      busy       <= (state_s != ST_IDLE);
      done       <= (state_s == ST_DONE);
      fault      <= (state_s == ST_FAULT);
    end
  end

endmodule

// File: doc/coin_payout.md
Name: coin_payout

Overview:
Downstream stage of the vending machine FSM. Consumes the one-cycle product/change/return results (pdt, cng, rtn), pulses the product vend motor, then pays the owed amount out of two coin hoppers (value-2 and value-1) one coin at a time over a req/ack handshake. It reports busy, completion, paid total and hopper faults to the top level.

Parameters:
VEND_PULSE_CYCLES, 4, cycles vend_motor stays high per product
ACK_TIMEOUT, 16, max cycles waiting for hop_ack high (and, separately, for hop_ack low) before FAULT
AMT_W, 3, width of amount inputs and paid_total

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
pdt  input  1  product release strobe from vending FSM
cng  input  AMT_W  change owed, valid when pdt=1
rtn  input  AMT_W  cancel refund; a nonzero value requests payout
coin2_stock  input  1  value-2 hopper non-empty
coin1_stock  input  1  value-1 hopper non-empty
hop_ack  input  1  hopper ack: coin ejected (shared by both hoppers)
vend_motor  output  1  product motor drive
hop2_req  output  1  eject one value-2 coin
hop1_req  output  1  eject one value-1 coin
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a transaction completes
paid_total  output  AMT_W  value paid in the current/last transaction
fault  output  1  sticky hopper fault

Behaviour:
- Reset (rst=0, async): state IDLE; vend_motor, hop2_req, hop1_req, busy, done, fault = 0; paid_total = 0; internal remain and timer = 0.
- Decisions are registered; outputs are Moore (decoded from state registers).
- IDLE: sample on each clk.
  - pdt=1: remain<=cng, paid_total<=0, go to VEND.
  - Else if rtn!=0: remain<=rtn, paid_total<=0, go to SELECT.
  - pdt=1 with rtn!=0 in the same cycle: pdt wins; rtn is discarded.
- pdt, cng and rtn are ignored in all states other than IDLE. No queuing.
- VEND: vend_motor=1 for exactly VEND_PULSE_CYCLES cycles, then go to SELECT.
- SELECT (1 cycle, no outputs beyond busy):
  - remain>=2 and coin2_stock: go to REQ2.
  - Else remain>=1 and coin1_stock: go to REQ1.
  - Else remain==0: go to DONE.
  - Else go to FAULT. This covers remain>=2 with only a value-1 hopper empty and no value-2 stock, and remain==1 with coin1 empty.
  - remain>=2 with coin2 empty but coin1 stocked uses REQ1 repeatedly.
- REQ2/REQ1: hop2_req/hop1_req=1. Timer counts from 0.
  - On hop_ack=1: remain -= value, paid_total += value (AMT_W-bit unsigned; never underflows because selection guarantees remain>=value). Go to ACKLOW; the req drops the next cycle.
  - Timer reaching ACK_TIMEOUT without ack: go to FAULT.
- ACKLOW: no req. Wait for hop_ack=0, then go to SELECT. The same ACK_TIMEOUT applies, else FAULT.
- DONE: done=1 for one cycle, then IDLE. paid_total holds until the next capture.
- FAULT: fault=1, busy=1, all reqs and motor 0. Held until reset. remain and paid_total are frozen for diagnosis.
- Zero-change product (pdt, cng=0): VEND, SELECT, DONE. paid_total=0.
- Max amount 7: three value-2 coins plus one value-1 coin.
- Reset mid-VEND/REQ: outputs drop immediately (async). Any partially counted coin is lost; no resume.

Test Plan:
1. pdt=1, cng=3, both hoppers stocked, ack 2 cycles after each req -> vend_motor high 4 cycles; hop2_req, then hop1_req; done pulse; paid_total=3; fault=0.
2. rtn=5, pdt=0 -> vend_motor never high; reqs in order 2,2,1; done; paid_total=5.
3. rtn=4, coin2_stock=0 -> four hop1_req handshakes; paid_total=4; done.
4. pdt=1, cng=1, coin1_stock=0 -> vend pulse completes, then fault=1, busy=1, paid_total=0; no done; fault persists until rst=0.
5. rtn=2, hop_ack held 0 -> hop2_req high exactly 16 cycles, then fault=1. Separately: ack stuck at 1 after a coin -> fault after 16 cycles in ACKLOW.
6. Reset and ignore checks:
   - rst=0 asserted mid REQ2 -> hop2_req, busy, paid_total go to 0 without a clock edge; IDLE after release.
   - pdt=1 with rtn=3 in the same cycle -> only cng paid.
   - rtn pulses while busy -> ignored.
